// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline-side interface for the hazard/stall controller
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              ex_memread;
    logic              ex_regwrite;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_memread;
    logic              mem_ready;
    logic              flush;
    logic              stall_front;
    logic              bubble_ex;
    logic              freeze_all;
    logic              mem_timeout_err;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_memread, ex_regwrite, ex_rd,
        output mem_memread, mem_ready, flush,
        input  stall_front, bubble_ex, freeze_all, mem_timeout_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_memread, ex_regwrite, ex_rd,
        input  mem_memread, mem_ready, flush,
        output stall_front, bubble_ex, freeze_all, mem_timeout_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use bubble insertion, memory-wait freeze and stall statistics
module hazard_ctrl_unit #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    hazard_ctrl_unit_if.slave  bus
);
    localparam int                TW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0]     LP_TMAX     = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0]     LP_TLAST    = TW'(MEM_TIMEOUT - 1);
    localparam logic [2:0]        LP_CNT_INIT = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LP_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LDUSE = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [TW-1:0]     r_tcnt;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic [REG_AW-1:0] w_id_rs1;
    logic [REG_AW-1:0] w_id_rs2;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_hit;
    logic              w_mem_wait;
    logic              w_stall_front;
    logic              w_bubble_ex;
    logic              w_freeze_all;

    assign w_id_rs1 = bus.id_rs1;
    assign w_id_rs2 = bus.id_rs2;
    assign w_ex_rd  = bus.ex_rd;

    assign w_hit = bus.ex_memread & bus.ex_regwrite & (w_ex_rd != '0) &
                   ((bus.id_rs1_used & (w_id_rs1 == w_ex_rd)) |
                    (bus.id_rs2_used & (w_id_rs2 == w_ex_rd)));

    assign w_mem_wait = bus.mem_memread & ~bus.mem_ready;

    // Priority: reset, then memory freeze, then flush, then load-use.
    always_comb begin
        w_stall_front = 1'b0;
        w_bubble_ex   = 1'b0;
        w_freeze_all  = 1'b0;
        if (i_reset) begin
            w_stall_front = 1'b0;
        end else if (w_mem_wait) begin
            w_freeze_all  = 1'b1;
            w_stall_front = 1'b1;
        end else if (bus.flush) begin
            w_stall_front = 1'b0;
        end else if ((r_state == LDUSE) || w_hit) begin
            w_stall_front = 1'b1;
            w_bubble_ex   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_cnt          <= 3'd0;
            r_tcnt         <= '0;
            r_timeout_err  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (w_mem_wait) begin
                // FSM and bubble counter are frozen with the rest of the pipeline.
                if (r_tcnt != LP_TMAX) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                if (r_tcnt >= LP_TLAST) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_tcnt <= '0;
                if (bus.flush) begin
                    r_state <= IDLE;
                    r_cnt   <= 3'd0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_hit && (LOAD_USE_CYCLES > 1)) begin
                                r_state <= LDUSE;
                                r_cnt   <= LP_CNT_INIT;
                            end
                        end
                        LDUSE: begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == 3'd1) begin
                                r_state <= IDLE;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_cnt   <= 3'd0;
                        end
                    endcase
                end
            end
            if (w_stall_front && (r_stall_cycles != LP_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign bus.stall_front     = w_stall_front;
    assign bus.bubble_ex       = w_bubble_ex;
    assign bus.freeze_all      = w_freeze_all;
    assign bus.mem_timeout_err = r_timeout_err;
    assign bus.stall_cycles    = r_stall_cycles;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // a: single-bubble config; b: two bubbles, 4-bit counter, timeout 4
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) a_if ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  b_if ();

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(1), .CNT_W(16), .MEM_TIMEOUT(255)) u_a (
        .i_clk(clk), .i_reset(reset), .bus(a_if.slave)
    );
    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(2), .CNT_W(4), .MEM_TIMEOUT(4)) u_b (
        .i_clk(clk), .i_reset(reset), .bus(b_if.slave)
    );

    function automatic logic [2:0] outs_a();
        return {a_if.stall_front, a_if.bubble_ex, a_if.freeze_all};
    endfunction

    function automatic logic [2:0] outs_b();
        return {b_if.stall_front, b_if.bubble_ex, b_if.freeze_all};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.id_rs1 = 5'd0; a_if.id_rs2 = 5'd0;
        a_if.id_rs1_used = 1'b0; a_if.id_rs2_used = 1'b0;
        a_if.ex_memread = 1'b0; a_if.ex_regwrite = 1'b0; a_if.ex_rd = 5'd0;
        a_if.mem_memread = 1'b0; a_if.mem_ready = 1'b0; a_if.flush = 1'b0;
    endtask

    task automatic idle_b();
        b_if.id_rs1 = 5'd0; b_if.id_rs2 = 5'd0;
        b_if.id_rs1_used = 1'b0; b_if.id_rs2_used = 1'b0;
        b_if.ex_memread = 1'b0; b_if.ex_regwrite = 1'b0; b_if.ex_rd = 5'd0;
        b_if.mem_memread = 1'b0; b_if.mem_ready = 1'b0; b_if.flush = 1'b0;
    endtask

    task automatic hit_b_rs2(input logic [4:0] rd);
        b_if.ex_memread = 1'b1; b_if.ex_regwrite = 1'b1; b_if.ex_rd = rd;
        b_if.id_rs2 = rd; b_if.id_rs2_used = 1'b1;
    endtask

    task automatic do_reset();
        idle_a(); idle_b();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_a(); idle_b();
        a_if.ex_memread = 1'b1; a_if.ex_regwrite = 1'b1; a_if.ex_rd = 5'd5;
        a_if.id_rs1 = 5'd5; a_if.id_rs1_used = 1'b1;
        a_if.mem_memread = 1'b1;
        hit_b_rs2(5'd3);
        b_if.mem_memread = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b000) begin n_err++; $display("FAIL reset_outs_a got=%b exp=000", outs_a()); end
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL reset_outs_b got=%b exp=000", outs_b()); end
        n_cmp++; if ({a_if.stall_cycles, a_if.mem_timeout_err} !== 17'd0) begin n_err++; $display("FAIL reset_regs_a got=%h exp=0", {a_if.stall_cycles, a_if.mem_timeout_err}); end
        n_cmp++; if ({b_if.stall_cycles, b_if.mem_timeout_err} !== 5'd0) begin n_err++; $display("FAIL reset_regs_b got=%h exp=0", {b_if.stall_cycles, b_if.mem_timeout_err}); end
        do_reset();
    endtask

    task automatic test_load_use_1();
        idle_a();
        a_if.ex_memread = 1'b1; a_if.ex_regwrite = 1'b1; a_if.ex_rd = 5'd5;
        a_if.id_rs1 = 5'd5; a_if.id_rs1_used = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b110) begin n_err++; $display("FAIL lu1_hit got=%b exp=110", outs_a()); end
        tick();
        idle_a();
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b000) begin n_err++; $display("FAIL lu1_after got=%b exp=000", outs_a()); end
        n_cmp++; if (a_if.stall_cycles !== 16'd1) begin n_err++; $display("FAIL lu1_count got=%0d exp=1", a_if.stall_cycles); end
        tick();
        a_if.ex_memread = 1'b1; a_if.ex_regwrite = 1'b1; a_if.ex_rd = 5'd9;
        a_if.id_rs2 = 5'd9; a_if.id_rs2_used = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b110) begin n_err++; $display("FAIL lu1_rs2_hit got=%b exp=110", outs_a()); end
        tick();
        idle_a();
        @(negedge clk);
        n_cmp++; if (a_if.stall_cycles !== 16'd2) begin n_err++; $display("FAIL lu1_rs2_count got=%0d exp=2", a_if.stall_cycles); end
        tick();
    endtask

    task automatic test_x0_unused();
        idle_a();
        a_if.ex_memread = 1'b1; a_if.ex_regwrite = 1'b1; a_if.ex_rd = 5'd0;
        a_if.id_rs1 = 5'd0; a_if.id_rs1_used = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b000) begin n_err++; $display("FAIL x0_nostall got=%b exp=000", outs_a()); end
        tick();
        a_if.ex_rd = 5'd7; a_if.id_rs1 = 5'd3; a_if.id_rs2 = 5'd7; a_if.id_rs2_used = 1'b0;
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b000) begin n_err++; $display("FAIL unused_rs2 got=%b exp=000", outs_a()); end
        tick();
        a_if.ex_regwrite = 1'b0; a_if.id_rs2_used = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_a() !== 3'b000) begin n_err++; $display("FAIL no_regwrite got=%b exp=000", outs_a()); end
        tick();
        idle_a();
        @(negedge clk);
        n_cmp++; if (a_if.stall_cycles !== 16'd2) begin n_err++; $display("FAIL x0_count got=%0d exp=2", a_if.stall_cycles); end
    endtask

    task automatic test_load_use_2();
        do_reset();
        hit_b_rs2(5'd12);
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b110) begin n_err++; $display("FAIL lu2_c1 got=%b exp=110", outs_b()); end
        tick();
        idle_b();
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b110) begin n_err++; $display("FAIL lu2_c2 got=%b exp=110", outs_b()); end
        tick();
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL lu2_c3 got=%b exp=000", outs_b()); end
        n_cmp++; if (b_if.stall_cycles !== 4'd2) begin n_err++; $display("FAIL lu2_count got=%0d exp=2", b_if.stall_cycles); end
        hit_b_rs2(5'd12);
        tick();
        idle_b();
        b_if.flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL lu2_flush got=%b exp=000", outs_b()); end
        tick();
        b_if.flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL lu2_post_flush got=%b exp=000", outs_b()); end
        n_cmp++; if (b_if.stall_cycles !== 4'd3) begin n_err++; $display("FAIL lu2_flush_count got=%0d exp=3", b_if.stall_cycles); end
        hit_b_rs2(5'd4);
        b_if.flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL hit_with_flush got=%b exp=000", outs_b()); end
        tick();
        idle_b();
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL hit_flush_idle got=%b exp=000", outs_b()); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hit_b_rs2(5'd6);
        tick();
        idle_b();
        b_if.mem_memread = 1'b1; b_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (outs_b() !== 3'b101) begin n_err++; $display("FAIL memwait_freeze%0d got=%b exp=101", i, outs_b()); end
            tick();
        end
        b_if.mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b110) begin n_err++; $display("FAIL memwait_resume got=%b exp=110", outs_b()); end
        tick();
        idle_b();
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL memwait_done got=%b exp=000", outs_b()); end
        n_cmp++; if (b_if.stall_cycles !== 4'd5) begin n_err++; $display("FAIL memwait_count got=%0d exp=5", b_if.stall_cycles); end
        n_cmp++; if (b_if.mem_timeout_err !== 1'b0) begin n_err++; $display("FAIL memwait_noerr got=%b exp=0", b_if.mem_timeout_err); end
    endtask

    task automatic test_timeout();
        do_reset();
        b_if.mem_memread = 1'b1; b_if.mem_ready = 1'b0;
        b_if.flush = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++; if (b_if.mem_timeout_err !== (k >= 5)) begin n_err++; $display("FAIL timeout_c%0d got=%b exp=%b", k, b_if.mem_timeout_err, (k >= 5)); end
            n_cmp++; if (outs_b() !== 3'b101) begin n_err++; $display("FAIL timeout_freeze%0d got=%b exp=101", k, outs_b()); end
            tick();
        end
        b_if.mem_ready = 1'b1; b_if.flush = 1'b0;
        tick();
        idle_b();
        tick();
        @(negedge clk);
        n_cmp++; if ({b_if.mem_timeout_err, outs_b()} !== 4'b1000) begin n_err++; $display("FAIL timeout_sticky got=%b exp=1000", {b_if.mem_timeout_err, outs_b()}); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (b_if.mem_timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_cleared got=%b exp=0", b_if.mem_timeout_err); end
    endtask

    task automatic test_reset_mid_lduse();
        do_reset();
        hit_b_rs2(5'd8);
        tick();
        idle_b();
        b_if.mem_memread = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL rst_mid_outs got=%b exp=000", outs_b()); end
        tick();
        reset = 1'b0;
        idle_b();
        @(negedge clk);
        n_cmp++; if (outs_b() !== 3'b000) begin n_err++; $display("FAIL rst_mid_idle got=%b exp=000", outs_b()); end
        n_cmp++; if (b_if.stall_cycles !== 4'd0) begin n_err++; $display("FAIL rst_mid_count got=%0d exp=0", b_if.stall_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        hit_b_rs2(5'd2);
        for (int i = 0; i < 14; i++) tick();
        @(negedge clk);
        n_cmp++; if (b_if.stall_cycles !== 4'd14) begin n_err++; $display("FAIL sat_pre got=%0d exp=14", b_if.stall_cycles); end
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        n_cmp++; if (b_if.stall_cycles !== 4'hF) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", b_if.stall_cycles); end
        n_cmp++; if (b_if.stall_front !== 1'b1) begin n_err++; $display("FAIL sat_stall got=%b exp=1", b_if.stall_front); end
        tick();
        idle_b();
    endtask

    initial begin
        reset = 1'b1;
        idle_a(); idle_b();
        test_reset();
        test_load_use_1();
        test_x0_unused();
        test_load_use_2();
        test_mem_wait();
        test_timeout();
        test_reset_mid_lduse();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
